pvr_vram_arbiter: RTL and testbench

PVR_VRAM_ARBITER -- requirements
Module: pvr_vram_arbiter

---
 rtl/pvr_pkg.sv | 13 +
 rtl/pvr_vram_arbiter_if.sv | 46 ++++
 rtl/pvr_rr_pick.sv | 27 ++
 rtl/pvr_vram_arbiter.sv | 151 +++++++++++++++
 tb/tb_pvr_vram_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pvr_pkg.sv
// Shared definitions for the PVR VRAM arbiter: FSM state encoding and VRAM bus widths.
package pvr_pkg;

  localparam int VRAM_AW = 24;
  localparam int VRAM_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DATA = 2'd2
  } pvr_state_e;

endpackage

// File: rtl/pvr_vram_arbiter_if.sv
// Requester and VRAM command bus of the PVR VRAM arbiter; master = arbiter side.
// Optional PVR_VRAM_ARB_LOCK_EN adds the per-requester req_lock signal.
interface pvr_vram_arbiter_if #(
  parameter int NUM_REQ = 3
);
  import pvr_pkg::*;

  logic [NUM_REQ-1:0]         req_rd;
  logic [NUM_REQ-1:0]         req_wr;
  logic [NUM_REQ*VRAM_AW-1:0] req_addr;
  logic [NUM_REQ*VRAM_DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]         req_ack;
  logic [VRAM_DW-1:0]         req_rdata;
`ifdef PVR_VRAM_ARB_LOCK_EN
  logic [NUM_REQ-1:0]         req_lock;
`endif

  logic                       vram_rd;
  logic                       vram_wr;
  logic [VRAM_AW-1:0]         vram_addr;
  logic [VRAM_DW-1:0]         vram_wdata;
  logic                       vram_wait;
  logic [VRAM_DW-1:0]         vram_din;
  logic                       vram_valid;

  modport master (
`ifdef PVR_VRAM_ARB_LOCK_EN
    input  req_lock,
`endif
    input  req_rd, req_wr, req_addr, req_wdata,
    output req_ack, req_rdata,
    output vram_rd, vram_wr, vram_addr, vram_wdata,
    input  vram_wait, vram_din, vram_valid
  );

  modport slave (
`ifdef PVR_VRAM_ARB_LOCK_EN
    output req_lock,
`endif
    output req_rd, req_wr, req_addr, req_wdata,
    input  req_ack, req_rdata,
    input  vram_rd, vram_wr, vram_addr, vram_wdata,
    output vram_wait, vram_din, vram_valid
  );

endinterface

// File: rtl/pvr_rr_pick.sv
// Round-robin priority encoder: first active request after 'last', wrapping modulo NUM_REQ.
module pvr_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [IW-1:0]      pick,
  output logic               valid
);

  always_comb begin
    int idx;
    // NOTE: outputs get a default before the loop so every path assigns them and no latch is inferred.
    pick  = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last) + i) % NUM_REQ;
      if (!valid && req[idx]) begin
        pick  = IW'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pvr_vram_arbiter.sv
// Single-outstanding VRAM arbiter with round-robin grant and bounded per-owner bursts.
// Define PVR_VRAM_ARB_LOCK_EN to let an owner holding req_lock keep the grant past BURST_MAX.
module pvr_vram_arbiter
  import pvr_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int BURST_MAX = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  pvr_vram_arbiter_if.master         bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);

  pvr_state_e          state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       last_owner_q, last_owner_d;
  logic [BW-1:0]       burst_cnt_q, burst_cnt_d;
  logic                post_ack_q, post_ack_d;
  logic                rd_q, rd_d, wr_q, wr_d;
  logic [VRAM_AW-1:0]  addr_q, addr_d;
  logic [VRAM_DW-1:0]  wdata_q, wdata_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [VRAM_DW-1:0]  rdata_q, rdata_d;

  logic [IW-1:0]       pick;
  logic                pick_valid;
  logic                owner_req;
  logic                burst_ok;
  logic                issue;
  logic [IW-1:0]       issue_idx;

  pvr_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr_pick (
    .req   (bus.req_rd | bus.req_wr),
    .last  (last_owner_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  assign owner_req = bus.req_rd[owner_q] | bus.req_wr[owner_q];

`ifdef PVR_VRAM_ARB_LOCK_EN
  assign burst_ok = (burst_cnt_q < BURST_LIM) || bus.req_lock[owner_q];
`else
  assign burst_ok = (burst_cnt_q < BURST_LIM);
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ack_d        = '0;
    rdata_d      = rdata_q;
    post_ack_d   = |ack_q;
    issue        = 1'b0;
    issue_idx    = owner_q;

    unique case (state_q)
      // While an ack is on the bus the requesters still show the completed request, so wait
      // one cycle; the following cycle decides between continuing the burst and rotating.
      ST_IDLE: begin
        if (ack_q == '0) begin
          if (post_ack_q && owner_req && burst_ok) begin
            issue = 1'b1;
            if (burst_cnt_q < BURST_LIM) burst_cnt_d = burst_cnt_q + 1'b1;
          end else if (pick_valid) begin
            issue        = 1'b1;
            issue_idx    = pick;
            owner_d      = pick;
            last_owner_d = pick;
            burst_cnt_d  = BW'(1);
          end
        end
      end
      ST_ISSUE: begin
        if (!bus.vram_wait) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (wr_q) begin
            ack_d[owner_q] = 1'b1;
            state_d        = ST_IDLE;
          end else begin
            state_d = ST_WAIT_DATA;
          end
        end
      end
      ST_WAIT_DATA: begin
        if (bus.vram_valid) begin
          rdata_d        = bus.vram_din;
          ack_d[owner_q] = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Write wins when a requester raises both rd and wr.
    if (issue) begin
      wr_d    = bus.req_wr[issue_idx];
      rd_d    = ~bus.req_wr[issue_idx];
      addr_d  = bus.req_addr[int'(issue_idx)*VRAM_AW +: VRAM_AW];
      wdata_d = bus.req_wdata[int'(issue_idx)*VRAM_DW +: VRAM_DW];
      state_d = ST_ISSUE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= IW'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
      post_ack_q   <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      post_ack_q   <= post_ack_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus.req_ack    = ack_q;
  assign bus.req_rdata  = rdata_q;
  assign bus.vram_rd    = rd_q;
  assign bus.vram_wr    = wr_q;
  assign bus.vram_addr  = addr_q;
  assign bus.vram_wdata = wdata_q;

endmodule

// File: tb/tb_pvr_vram_arbiter.sv
// Directed bench for pvr_vram_arbiter: vector table of arbitration rounds plus burst, stall and reset sequences.
module tb_pvr_vram_arbiter;
  import pvr_pkg::*;

  localparam int NR = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pvr_vram_arbiter_if #(.NUM_REQ(NR)) bus ();

  pvr_vram_arbiter #(.NUM_REQ(NR), .BURST_MAX(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        lock;
    logic [23:0] addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct packed {
    logic             rst;
    logic [2:0][1:0]  op;     // per requester {r2,r1,r0}: bit0 read, bit1 write
    logic [2:0][23:0] addr;
    logic [2:0][31:0] wdata;
    logic [3:0]       lat;
    logic [3:0]       stall;
    logic [1:0]       n_exp;
    logic [2:0][1:0]  order;  // order[0] is the first ack expected
    logic [2:0][31:0] rdata;  // expected read data per requester
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  op_t         ops_q [NR][$];
  logic [1:0]  ack_idx [$];
  logic [31:0] ack_data [$];

  // VRAM model state
  logic [31:0] mem [logic [23:0]];
  int          lat = 1;
  int          stall_cfg = 0;
  int          stall_left = 0;
  int          rd_cnt = 0;
  bit          rd_pending = 0;
  logic [31:0] rd_val = '0;
  int          cmd_cycles = 0;
  int          last_cmd_cycles = 0;
  bit          cmd_unstable = 0;
  logic [23:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  int          accepts = 0;
  bit          both_hi = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input int r, input op_t op);
    bus.req_rd[r]              = op.rd;
    bus.req_wr[r]              = op.wr;
    bus.req_addr[r*24 +: 24]   = op.addr;
    bus.req_wdata[r*32 +: 32]  = op.wdata;
`ifdef PVR_VRAM_ARB_LOCK_EN
    bus.req_lock[r]            = op.lock;
`endif
  endtask

  task automatic clear_req(input int r);
    op_t z;
    z = '0;
    drive_req(r, z);
  endtask

  // VRAM model: decides vram_wait/vram_valid at each negedge for the following posedge.
  initial begin
    bus.vram_wait  = 1'b0;
    bus.vram_valid = 1'b0;
    bus.vram_din   = '0;
    forever begin
      @(negedge clock);
      bus.vram_valid = 1'b0;
      if (rd_pending) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          bus.vram_valid = 1'b1;
          bus.vram_din   = rd_val;
          rd_pending     = 0;
        end
      end
      if (bus.vram_rd && bus.vram_wr) both_hi = 1;
      if (bus.vram_rd || bus.vram_wr) begin
        if (cmd_cycles == 0) begin
          cmd_addr   = bus.vram_addr;
          cmd_wdata  = bus.vram_wdata;
          stall_left = stall_cfg;
        end else if (bus.vram_addr !== cmd_addr || bus.vram_wdata !== cmd_wdata) begin
          cmd_unstable = 1;
        end
        cmd_cycles++;
        if (stall_left > 0) begin
          bus.vram_wait = 1'b1;
          stall_left--;
        end else begin
          bus.vram_wait   = 1'b0;
          accepts++;
          last_cmd_cycles = cmd_cycles;
          cmd_cycles      = 0;
          if (bus.vram_wr) mem[bus.vram_addr] = bus.vram_wdata;
          else begin
            rd_pending = 1;
            rd_cnt     = lat;
            rd_val     = mem.exists(bus.vram_addr) ? mem[bus.vram_addr] : {8'hEE, bus.vram_addr};
          end
        end
      end else begin
        bus.vram_wait = 1'b0;
        cmd_cycles    = 0;
      end
    end
  end

  task automatic log_acks();
    for (int r = 0; r < NR; r++)
      if (bus.req_ack[r]) begin
        ack_idx.push_back(2'(r));
        ack_data.push_back(bus.req_rdata);
      end
  endtask

  // Requester model: each requester works through its op queue, holding each op until its ack.
  task automatic run(input int budget);
    bit  act  [NR];
    bit  ackd [NR];
    bit  done;
    op_t op;
    done = 0;
    for (int r = 0; r < NR; r++) begin act[r] = 0; ackd[r] = 0; end
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clock); #1;
      for (int r = 0; r < NR; r++) begin
        if (act[r] && ackd[r]) begin act[r] = 0; ackd[r] = 0; end
        if (!act[r]) begin
          if (ops_q[r].size() > 0) begin
            op = ops_q[r].pop_front();
            drive_req(r, op);
            act[r] = 1;
          end else clear_req(r);
        end
      end
      if (!act[0] && !act[1] && !act[2]) done = 1;
      else begin
        @(negedge clock);
        for (int r = 0; r < NR; r++) if (bus.req_ack[r] && act[r]) ackd[r] = 1;
        log_acks();
      end
    end
    check("run_completed_in_budget", 64'(done), 64'd1);
    repeat (4) begin
      @(negedge clock);
      log_acks();
    end
  endtask

  task automatic do_reset(input bit chk);
    @(posedge clock); #1;
    reset = 1'b1;
    for (int r = 0; r < NR; r++) clear_req(r);
    @(posedge clock); #1;
    if (chk) begin
      @(negedge clock);
      check("reset_vram_cmd", {bus.vram_rd, bus.vram_wr, bus.vram_addr, bus.vram_wdata}, 64'd0);
      check("reset_req_ack", 64'(bus.req_ack), 64'd0);
      check("reset_req_rdata", 64'(bus.req_rdata), 64'd0);
      check("reset_state", 64'(dut.state_q), 64'(ST_IDLE));
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  localparam int NV = 5;
  vec_t vecs [NV];

  initial begin
    op_t op;
    int  spurious;
    int  waited;
    int  start_acc;

    vecs[0] = '{rst:1'b0, op:{2'b00, 2'b01, 2'b00}, addr:{24'h0, 24'h00408C, 24'h0}, wdata:'0,
                lat:4'd2, stall:4'd0, n_exp:2'd1, order:{2'd0, 2'd0, 2'd1},
                rdata:{32'h0, 32'hC8000000, 32'h0}};
    vecs[1] = '{rst:1'b1, op:{2'b11, 2'b01, 2'b10}, addr:{24'h000200, 24'h000020, 24'h000100},
                wdata:{32'h22222222, 32'h0, 32'h11111111},
                lat:4'd1, stall:4'd0, n_exp:2'd3, order:{2'd2, 2'd1, 2'd0},
                rdata:{32'h0, 32'hEE000020, 32'h0}};
    vecs[2] = '{rst:1'b0, op:{2'b01, 2'b00, 2'b01}, addr:{24'h000200, 24'h0, 24'h000100}, wdata:'0,
                lat:4'd1, stall:4'd2, n_exp:2'd2, order:{2'd0, 2'd2, 2'd0},
                rdata:{32'h22222222, 32'h0, 32'h11111111}};
    vecs[3] = '{rst:1'b0, op:{2'b01, 2'b10, 2'b00}, addr:{24'h000020, 24'h00408C, 24'h0},
                wdata:{32'h0, 32'hDEADBEEF, 32'h0},
                lat:4'd3, stall:4'd1, n_exp:2'd2, order:{2'd0, 2'd2, 2'd1},
                rdata:{32'hEE000020, 32'h0, 32'h0}};
    vecs[4] = '{rst:1'b0, op:{2'b00, 2'b01, 2'b01}, addr:{24'h0, 24'h00408C, 24'h000030}, wdata:'0,
                lat:4'd2, stall:4'd0, n_exp:2'd2, order:{2'd0, 2'd1, 2'd0},
                rdata:{32'h0, 32'hDEADBEEF, 32'hEE000030}};

    mem[24'h00408C] = 32'hC8000000;
    bus.req_rd = '0; bus.req_wr = '0; bus.req_addr = '0; bus.req_wdata = '0;
`ifdef PVR_VRAM_ARB_LOCK_EN
    bus.req_lock = '0;
`endif
    do_reset(1'b0);

    for (int v = 0; v < NV; v++) begin
      if (vecs[v].rst) do_reset(1'b0);
      lat       = int'(vecs[v].lat);
      stall_cfg = int'(vecs[v].stall);
      ack_idx.delete();
      ack_data.delete();
      for (int r = 0; r < NR; r++)
        if (vecs[v].op[r] != 2'b00) begin
          op = '{rd:vecs[v].op[r][0], wr:vecs[v].op[r][1], lock:1'b0,
                 addr:vecs[v].addr[r], wdata:vecs[v].wdata[r]};
          ops_q[r].push_back(op);
        end
      run(400);
      check($sformatf("v%0d_ack_count", v), 64'(ack_idx.size()), 64'(vecs[v].n_exp));
      for (int i = 0; i < int'(vecs[v].n_exp) && i < ack_idx.size(); i++) begin
        check($sformatf("v%0d_grant%0d_owner", v, i), 64'(ack_idx[i]), 64'(vecs[v].order[i]));
        if (vecs[v].op[ack_idx[i]] == 2'b01)
          check($sformatf("v%0d_grant%0d_rdata", v, i), 64'(ack_data[i]), 64'(vecs[v].rdata[ack_idx[i]]));
      end
    end

    // Write held under vram_wait for 5 cycles.
    do_reset(1'b1);
    stall_cfg = 5;
    lat       = 1;
    ack_idx.delete(); ack_data.delete();
    op = '{rd:1'b0, wr:1'b1, lock:1'b0, addr:24'h000100, wdata:32'hA5A5A5A5};
    ops_q[0].push_back(op);
    run(100);
    check("stall_ack_count", 64'(ack_idx.size()), 64'd1);
    check("stall_cmd_cycles", 64'(last_cmd_cycles), 64'd6);
    check("stall_cmd_stable", 64'(cmd_unstable), 64'd0);
    check("stall_write_data", 64'(mem[24'h000100]), 64'hA5A5A5A5);
    stall_cfg = 0;

    // Reset while waiting for read data; the late vram_valid must be ignored.
    do_reset(1'b0);
    lat       = 8;
    start_acc = accepts;
    @(posedge clock); #1;
    op = '{rd:1'b1, wr:1'b0, lock:1'b0, addr:24'h000300, wdata:32'h0};
    drive_req(2, op);
    waited = 0;
    while (accepts == start_acc && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    check("abort_read_accepted", 64'(accepts != start_acc), 64'd1);
    @(posedge clock); #1;
    @(negedge clock);
    check("abort_in_wait_data", 64'(dut.state_q), 64'(ST_WAIT_DATA));
    @(posedge clock); #1;
    reset = 1'b1;
    clear_req(2);
    @(posedge clock); #1;
    reset = 1'b0;
    spurious = 0;
    repeat (15) begin
      @(negedge clock);
      if (bus.req_ack != '0) spurious++;
    end
    check("abort_no_ack", 64'(spurious), 64'd0);
    check("abort_state_idle", 64'(dut.state_q), 64'(ST_IDLE));
    check("abort_vram_rd_low", 64'(bus.vram_rd), 64'd0);

    // Requester 1 streams 20 reads while requester 2 waits: burst of 16, then 2, then 1 resumes.
    do_reset(1'b0);
    lat = 1;
    ack_idx.delete(); ack_data.delete();
    for (int i = 0; i < 20; i++) begin
      op = '{rd:1'b1, wr:1'b0, lock:1'b0, addr:24'(24'h001000 + 4 * i), wdata:32'h0};
      ops_q[1].push_back(op);
    end
    op = '{rd:1'b1, wr:1'b0, lock:1'b0, addr:24'h002000, wdata:32'h0};
    ops_q[2].push_back(op);
    run(600);
    check("burst_ack_count", 64'(ack_idx.size()), 64'd21);
    for (int i = 0; i < 21 && i < ack_idx.size(); i++)
      check($sformatf("burst_grant%0d_owner", i), 64'(ack_idx[i]), (i == 16) ? 64'd2 : 64'd1);
    check("burst_grant0_rdata", 64'(ack_data[0]), 64'hEE001000);

`ifdef PVR_VRAM_ARB_LOCK_EN
    // Locked owner keeps the grant beyond BURST_MAX.
    do_reset(1'b0);
    ack_idx.delete(); ack_data.delete();
    for (int i = 0; i < 30; i++) begin
      op = '{rd:1'b1, wr:1'b0, lock:1'b1, addr:24'(24'h003000 + 4 * i), wdata:32'h0};
      ops_q[0].push_back(op);
    end
    op = '{rd:1'b1, wr:1'b0, lock:1'b0, addr:24'h004000, wdata:32'h0};
    ops_q[1].push_back(op);
    run(800);
    check("lock_ack_count", 64'(ack_idx.size()), 64'd31);
    for (int i = 0; i < 31 && i < ack_idx.size(); i++)
      check($sformatf("lock_grant%0d_owner", i), 64'(ack_idx[i]), (i == 30) ? 64'd1 : 64'd0);
`endif

    check("vram_rd_wr_exclusive", 64'(both_hi), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
